// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - EX-stage sequencer for the pipelined multiplier and iterative divider
// Optional feature macro: MULDIV_DIV0_FAST_EN (divide-by-zero bypasses the divider)
module muldiv_seq #(
    parameter int MULT_LAT = 6
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    input  logic        pipe_stall_i,
    input  logic [63:0] mult_p_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic [31:0] mult_a_o,
    output logic [31:0] mult_b_o,
    output logic        mult_ce_o,
    output logic        mult_sign_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    output logic        div_valid_o,
    output logic        div_sign_o,
    output logic        div_abort_o,
    output logic        busy_stall_o,
    output logic        result_valid_o,
    output logic [63:0] result_o
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_MUL       = 3'd1;
    localparam logic [2:0] S_DIV_START = 3'd2;
    localparam logic [2:0] S_DIV_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE      = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic          msign_q, msign_d;
    logic          dsign_q, dsign_d;
    logic [63:0]   result_q, result_d;
    logic          accept;
    logic          in_flight;

    // A new op is taken from IDLE, or straight out of DONE once the pipeline consumes the result
    assign accept    = start_i & ~flush_i &
                       ((state_q == S_IDLE) | ((state_q == S_DONE) & ~pipe_stall_i));
    assign in_flight = (state_q == S_MUL) | (state_q == S_DIV_START) | (state_q == S_DIV_WAIT);

    // Next-state, operand capture and result capture
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        msign_d  = msign_q;
        dsign_d  = dsign_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: ;
            S_MUL: begin
                if (cnt_q == '0) begin
                    result_d = mult_p_i;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV_START: state_d = S_DIV_WAIT;
            S_DIV_WAIT: begin
                if (div_ready_i) begin
                    result_d = div_result_i;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (!pipe_stall_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            a_d     = src_a_i;
            b_d     = src_b_i;
            msign_d = (op_i == 2'b00);
            dsign_d = (op_i == 2'b10);
            if (!op_i[1]) begin
                state_d = S_MUL;
                cnt_d   = CW'(MULT_LAT - 1);
            end else begin
`ifdef MULDIV_DIV0_FAST_EN
                if (src_b_i == 32'd0) begin
                    state_d  = S_DONE;
                    result_d = {src_a_i, 32'hFFFF_FFFF};
                end else begin
                    state_d = S_DIV_START;
                end
`else
                state_d = S_DIV_START;
`endif
            end
        end

        // Flush wins over everything, including a result arriving this cycle
        if (flush_i) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            msign_q  <= 1'b0;
            dsign_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            msign_q  <= msign_d;
            dsign_q  <= dsign_d;
            result_q <= result_d;
        end
    end

    assign mult_a_o       = a_q;
    assign mult_b_o       = b_q;
    assign mult_ce_o      = (state_q == S_MUL);
    assign mult_sign_o    = msign_q;
    assign div_a_o        = a_q;
    assign div_b_o        = b_q;
    assign div_valid_o    = (state_q == S_DIV_START);
    assign div_sign_o     = dsign_q;
    assign div_abort_o    = flush_i & ((state_q == S_DIV_START) | (state_q == S_DIV_WAIT));
    assign busy_stall_o   = accept | in_flight;
    assign result_valid_o = (state_q == S_DONE);
    assign result_o       = result_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

EX-stage sequencer for the multi-cycle multiply and divide resources. Accepts one mult/div operation per issue, drives the CE-gated pipelined multiplier and the valid/ready iterative divider, stalls the pipeline while the operation is in flight, and holds the 64-bit {hi,lo} result until the pipeline consumes it. Flush aborts any in-flight operation within one cycle.

## Interface
- MULT_LAT, 6, multiplier pipeline depth in cycles (≥1); product valid MULT_LAT CE-cycles after operands are presented
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  issue pulse: a mult/div op is in EX and not stalled from D
- op  in  2  00 signed mult, 01 unsigned mult, 10 signed div, 11 unsigned div
- src_a  in  32  operand A / dividend
- src_b  in  32  operand B / divisor
- flush  in  1  pipeline flush of EX
- pipe_stall  in  1  downstream stall; result must be held
- mult_p  in  64  multiplier product
- div_ready  in  1  divider done pulse
- div_result  in  64  divider {remainder, quotient}
- mult_a, mult_b  out  32  latched operands to multiplier
- mult_ce  out  1  multiplier clock enable
- mult_sign  out  1  1 = signed product selected
- div_a, div_b  out  32  latched operands to divider
- div_valid  out  1  one-cycle divider start
- div_sign  out  1  1 = signed divide
- div_abort  out  1  divider flush
- busy_stall  out  1  stall request to pipeline control
- result_valid  out  1  result holds a completed {hi,lo}
- result  out  64  {hi, lo}

## Operation
- States: IDLE, MUL, DIV_START, DIV_WAIT, DONE.
- IDLE: start & ~flush latches src_a/src_b/op into operand regs; op[1]=0 → MUL, cnt ← MULT_LAT-1; op[1]=1 → DIV_START.
- MUL: mult_ce=1; cnt decrements; at cnt==0 edge, result ← mult_p → DONE.
- DIV_START: div_valid=1 for exactly this cycle → DIV_WAIT.
- DIV_WAIT: on div_ready, result ← div_result → DONE. No timeout.
- DONE: result_valid=1. ~pipe_stall → IDLE, or, if start & ~flush in the same cycle, accept the new op directly (back-to-back). pipe_stall → remain, result stable.
- mult_sign = latched op==00; div_sign = latched op==10; both stable for the whole operation.
- busy_stall = (IDLE|DONE) & start & ~flush | state∈{MUL, DIV_START, DIV_WAIT}.
- Flush: in any state, next state IDLE, result_valid cleared, cnt cleared; div_abort=1 combinationally during flush while in DIV_START/DIV_WAIT; start ignored in flush cycle (flush dominates). Concurrent div_ready and flush: result discarded.
- mult_ce=0 and div_valid=0 outside MUL/DIV_START.

## Timing
- Reset: state IDLE; all outputs 0; result 64'b0; cnt 0.
- Mult: start at cycle T → busy_stall high T..T+MULT_LAT; mult_ce high T+1..T+MULT_LAT; result_valid high from T+MULT_LAT+1.
- Div: start at T → div_valid at T+1; div_ready at cycle R → result_valid from R+1; busy_stall high T..R.
- busy_stall low in DONE; downstream consumes result in the first DONE cycle with pipe_stall=0.
- Reset asserted mid-operation: immediate return to reset values, no divider handshake.

## Configuration
- MULDIV_DIV0_FAST_EN defined: div with src_b==0 at issue skips the divider (no div_valid); next state DONE with result = {src_a, 32'hFFFF_FFFF}, result_valid at T+1, busy_stall only in T.
- Undefined: divide-by-zero issued to divider like any other divide.

## Test plan
- Signed mult, MULT_LAT=6, src_a=0xFFFF_FFFE, src_b=3 → mult_ce high 6 cycles, result=0xFFFF_FFFF_FFFF_FFFA at T+7, busy_stall low at T+7.
- Unsigned div 100/7, divider model ready after 33 cycles → single div_valid at T+1, result={2,14} the cycle after div_ready.
- Flush in DIV_WAIT with div_ready same cycle → div_abort=1, IDLE next, result_valid=0, result discarded.
- DONE with pipe_stall held 3 cycles → result and result_valid stable 3 cycles; new start accepted on the release cycle with back-to-back mult.
- rst low during MUL → all outputs 0 immediately; after release start works normally.
- Div 5/0: with MULDIV_DIV0_FAST_EN → no div_valid, result={5, 0xFFFF_FFFF} at T+1; without → div_valid at T+1.
